// File: rtl/mem_top.sv
// rtl/mem_top.sv - MIPS MEM stage: EX/MEM register, wait-state data memory, MEM/WB register
// Loads/stores hold the stage for WAIT_CYCLES cycles; ALU ops and misaligned accesses pass in one cycle.
module mem_top #(
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] alu_result,
  input  logic        zero_in,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write_in,
  input  logic        branch,
  output logic        stall,
  output logic        branch_taken,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        misalign
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam bit         NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_N  = 4'(WAIT_CYCLES);

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic        s_valid, s_zero, s_read, s_write, s_regw, s_branch;
  logic [31:0] s_alu, s_store;
  logic [4:0]  s_rd;

  logic [31:0] mem [DEPTH];

  logic [ADDR_W-1:0] addr;
  logic              misaligned, memop, done, wb_fire;

  // Upper address bits are dropped on purpose so the memory wraps.
  assign addr       = s_alu[ADDR_W+1:2];
  assign misaligned = s_valid & (s_read | s_write) & (s_alu[1:0] != 2'b00);
  assign memop      = s_valid & (s_read | s_write) & (s_alu[1:0] == 2'b00);
  assign done       = ((state == ST_IDLE) & NO_WAIT) | ((state == ST_WAIT) & (cnt == 4'd1));
  assign stall      = memop & ~done;
  assign wb_fire    = s_valid & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (memop && !NO_WAIT) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = WAIT_N;
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid  <= 1'b0;
      s_zero   <= 1'b0;
      s_read   <= 1'b0;
      s_write  <= 1'b0;
      s_regw   <= 1'b0;
      s_branch <= 1'b0;
      s_alu    <= 32'd0;
      s_store  <= 32'd0;
      s_rd     <= 5'd0;
    end else if (!stall) begin
      s_valid <= enable;
      if (enable) begin
        s_zero   <= zero_in;
        s_read   <= mem_read;
        s_write  <= mem_write;
        s_regw   <= reg_write_in;
        s_branch <= branch;
        s_alu    <= alu_result;
        s_store  <= store_data;
        s_rd     <= rd_in;
      end
    end
  end

  // The array has no reset; a reset edge must still suppress a pending store.
  always_ff @(posedge clk) begin
    if (!rst && wb_fire && memop && s_write) mem[addr] <= s_store;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_data      <= 32'd0;
      wb_rd        <= 5'd0;
      wb_reg_write <= 1'b0;
      branch_taken <= 1'b0;
      misalign     <= 1'b0;
    end else if (wb_fire) begin
      wb_valid     <= 1'b1;
      wb_data      <= (memop && s_read) ? mem[addr] : s_alu;
      wb_rd        <= s_rd;
      wb_reg_write <= s_regw & ~misaligned;
      branch_taken <= s_branch & s_zero;
      misalign     <= misaligned;
    end else begin
      wb_valid     <= 1'b0;
      branch_taken <= 1'b0;
      misalign     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_top.sv
// tb/tb_mem_top.sv - randomized self-checking bench for mem_top against a transaction-level model
module tb_mem_top;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] alu_result = '0;
  logic        zero_in = 1'b0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd_in = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        reg_write_in = 1'b0;
  logic        branch = 1'b0;
  logic        stall, branch_taken, wb_valid, wb_reg_write, misalign;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  logic [31:0] model [64];
  int checks = 0;
  int errors = 0;

  mem_top #(.DEPTH(64), .ADDR_W(6), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .alu_result(alu_result), .zero_in(zero_in),
    .store_data(store_data), .rd_in(rd_in), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write_in(reg_write_in), .branch(branch), .stall(stall), .branch_taken(branch_taken),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic garble();
    enable       = 1'($urandom_range(0, 1));
    alu_result   = $urandom;
    store_data   = $urandom;
    rd_in        = 5'($urandom);
    mem_read     = 1'($urandom);
    mem_write    = 1'($urandom);
    reg_write_in = 1'($urandom);
    branch       = 1'($urandom);
    zero_in      = 1'($urandom);
  endtask

  // Issue one instruction alone and check its writeback against the model.
  task automatic exec(input logic rd_op, input logic wr_op, input logic regw, input logic br,
                      input logic z, input logic [31:0] alu, input logic [31:0] sd,
                      input logic [4:0] rd5);
    logic        mis, mop, ok;
    logic [31:0] exp_data;
    int          a, stalls;
    mis = (rd_op | wr_op) && (alu[1:0] != 2'b00);
    mop = (rd_op | wr_op) && !mis;
    a = int'(alu[7:2]);
    exp_data = (mop && rd_op) ? model[a] : alu;
    if (mop && wr_op) model[a] = sd;

    @(negedge clk);
    enable = 1'b1; alu_result = alu; store_data = sd; rd_in = rd5; mem_read = rd_op;
    mem_write = wr_op; reg_write_in = regw; branch = br; zero_in = z;
    stalls = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall) begin
        stalls++;
        garble();
      end else begin
        enable = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    check("no_timeout", 32'(ok), 32'd1);
    check("stall_cycles", 32'(stalls), mop ? 32'(W) : 32'd0);
    @(negedge clk);
    check("wb_valid", 32'(wb_valid), 32'd1);
    check("wb_data", wb_data, exp_data);
    check("wb_rd", 32'(wb_rd), 32'(rd5));
    check("wb_reg_write", 32'(wb_reg_write), 32'(regw & ~mis));
    check("branch_taken", 32'(branch_taken), 32'(br & z));
    check("misalign", 32'(misalign), 32'(mis));
    @(negedge clk);
    check("wb_valid_drop", 32'(wb_valid), 32'd0);
    check("branch_drop", 32'(branch_taken), 32'd0);
    check("misalign_drop", 32'(misalign), 32'd0);
    check("wb_data_hold", wb_data, exp_data);
    check("idle_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    int kind;
    logic [31:0] a32;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_branch", 32'(branch_taken), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 64; i++)
      exec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'(i * 4), $urandom, 5'd0);

    exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 5'd5);
    exec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'hDEADBEEF, 5'd0);
    exec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'd0, 5'd9);
    exec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h1234, 5'd0);
    exec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 5'd2);
    exec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h6, 32'd0, 5'd3);
    exec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h5, 32'hFFFF0000, 5'd0);
    exec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4, 32'd0, 5'd4);
    exec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'd0, 5'd0);
    exec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 32'd0, 5'd0);

    // Reset one cycle into a store's wait: the store must be lost.
    exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h77, 32'd0, 5'd7);
    @(negedge clk);
    enable = 1'b1; alu_result = 32'h20; store_data = 32'hCAFEF00D; mem_read = 1'b0;
    mem_write = 1'b1; reg_write_in = 1'b0; branch = 1'b0; zero_in = 1'b0; rd_in = 5'd0;
    @(negedge clk);
    enable = 1'b0;
    check("pre_rst_stall", 32'(stall), 32'd1);
    @(negedge clk);
    check("wait_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_wb_data", wb_data, 32'd0);
    check("mid_rst_wb_rd", 32'(wb_rd), 32'd0);
    check("mid_rst_wb_regw", 32'(wb_reg_write), 32'd0);
    check("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'd0, 5'd11);

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 3);
      a32 = $urandom;
      if (kind != 0 && $urandom_range(0, 3) != 0) a32[1:0] = 2'b00;
      exec(kind == 1 || kind == 3, kind == 2 || kind == 3, 1'($urandom), 1'($urandom),
           1'($urandom), a32, $urandom, 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_top.md
Name: mem_top

Overview:
- Memory-access (MEM) stage of the 5-stage MIPS pipeline; sits directly downstream of the execute stage and consumes its result/zero outputs.
- Contains the EX/MEM pipeline register, a word-addressed data memory with programmable access latency, and the MEM/WB output register.
- Produces the branch-taken decision from the EX zero flag.
- Stalls the upstream stages while a load or store is in flight.

Parameters:
- DEPTH, 64, data memory size in 32-bit words.
- ADDR_W, 6, word-address width; DEPTH = 2**ADDR_W.
- WAIT_CYCLES, 2, extra cycles a load/store occupies the stage (0..15).

Ports:
- clk  input  1  stage clock, rising edge
- rst  input  1  asynchronous, active-high reset
- enable  input  1  stage advance enable from pipeline control
- alu_result  input  32  EX result; byte address for loads/stores
- zero_in  input  1  EX zero flag
- store_data  input  32  rt value for stores
- rd_in  input  5  destination register
- mem_read  input  1  load instruction
- mem_write  input  1  store instruction
- reg_write_in  input  1  instruction writes the register file
- branch  input  1  beq instruction
- stall  output  1  hold upstream stages (combinational from state)
- branch_taken  output  1  registered branch & zero
- wb_valid  output  1  MEM/WB entry valid
- wb_data  output  32  load data or passed-through ALU result
- wb_rd  output  5  destination register
- wb_reg_write  output  1  register-file write enable for WB
- misalign  output  1  one-cycle pulse: load/store with alu_result[1:0] != 0

Behaviour:
- Reset (async):
  - All outputs go to 0, FSM goes to IDLE, counter goes to 0, and s_valid clears.
  - Memory array contents are not cleared.
  - A reset asserted mid-access abandons the access: no memory write, no WB.
- EX/MEM register S:
  - S loads all inputs at a clock edge when enable=1 and stall=0; s_valid <= 1 at that edge.
  - When enable=0 and stall=0, s_valid <= 0 (bubble).
- memop = s_valid & (mem_read | mem_write) & (alu_result[1:0] == 0), all taken from S.
- Word address = alu_result[ADDR_W+1:2]; upper bits are ignored, so addresses wrap modulo DEPTH.
- FSM states: IDLE and WAIT, plus a 4-bit counter cnt.
  - done = (state==IDLE & WAIT_CYCLES==0) | (state==WAIT & cnt==1).
  - stall = memop & ~done.
  - IDLE with memop and WAIT_CYCLES>0 -> WAIT, cnt <= WAIT_CYCLES.
  - WAIT -> cnt decrements each edge.
  - WAIT at an edge with done -> IDLE.
- Access and writeback edge:
  - For memop this is the edge where done=1. For non-memop S contents, it is the edge after S loads.
  - Store: mem[addr] <= store_data.
  - Load: wb_data <= mem[addr] (synchronous read).
  - Otherwise: wb_data <= alu_result.
  - wb_rd <= rd; wb_valid <= s_valid; wb_reg_write <= s_valid & reg_write & ~misaligned.
- Latency:
  - Non-memory op: WB outputs appear 1 edge after S loads.
  - Load/store: WB outputs appear 1+WAIT_CYCLES edges after S loads; stall is high for exactly WAIT_CYCLES cycles.
- Misaligned load/store:
  - No memory access, no stall.
  - misalign=1 for one cycle at the writeback edge; wb_reg_write=0.
- branch_taken <= s_valid & branch & zero_in, registered at the writeback edge; it is 0 in every other cycle.
- Store followed by load to the same address: the load returns the new data, because the store completes at an earlier edge.
- The enable input is ignored while stall=1; the counter continues regardless of enable.
- When nothing is captured, WB outputs hold except wb_valid, branch_taken and misalign, which go to 0.

Test Plan:
- Reset then ALU op (alu_result=0x0000_0010, rd=5, reg_write=1, enable=1), no stall -> one edge later wb_data=0x10, wb_rd=5, wb_reg_write=1, stall never high.
- Store 0xDEADBEEF to address 0x8, then load from 0x8 to rd=9, WAIT_CYCLES=2 -> stall high 2 cycles per op; load WB shows wb_data=0xDEADBEEF, wb_rd=9, 3 edges after the load enters S.
- Address wrap: store 0x1234 to 0x100 (word 64 -> 0), then load 0x0 -> wb_data=0x1234.
- Load from 0x6 (misaligned) -> misalign pulses for 1 cycle, wb_reg_write=0, stall=0, memory unchanged.
- branch=1 with zero_in=1, then branch=1 with zero_in=0 -> branch_taken=1 for one cycle, then 0.
- Assert rst 1 cycle into a store wait (WAIT_CYCLES=2) -> all outputs 0 immediately, FSM IDLE, later load of that address returns the prior contents.
